cs_feeder: RTL

CS_FEEDER -- requirements
Module: cs_feeder

---
 rtl/cs_feeder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/cs_feeder.sv
// Feeds frames of FIFO-buffered host samples to a computational system and returns its results.
// Define CS_FEEDER_STATS_EN to add the per-frame res_max / res_cnt statistics outputs.
module cs_feeder (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       start,
   input  logic [7:0] frame_len,
   output logic [7:0] X,
   output logic       cs_reset,
   input  logic [9:0] Y,
   output logic [9:0] res_data,
   output logic       res_valid,
`ifdef CS_FEEDER_STATS_EN
   output logic [9:0] res_max,
   output logic [7:0] res_cnt,
`endif
   output logic       busy,
   output logic       done,
   output logic       err
);

   typedef enum logic [1:0] {IDLE, CLEAR, SEND, DRAIN} state_t;

   state_t      state, state_nxt;

   logic [7:0]  mem [16];
   logic [3:0]  wr_ptr, rd_ptr;
   logic [4:0]  count;
   logic        fifo_empty, fifo_full;
   logic        push, pop;

   logic [7:0]  len_q;
   logic [7:0]  idx;
   logic        drain_cnt;
   logic        start_acc, err_set, abort, done_set;
   logic        vld_x, vld_y;

   assign fifo_empty = (count == 5'd0);
   assign fifo_full  = (count == 5'd16);
   assign in_ready   = ~fifo_full;
   assign push       = in_valid & in_ready;
   assign busy       = (state != IDLE);

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      start_acc = 1'b0;
      err_set   = 1'b0;
      abort     = 1'b0;
      done_set  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (frame_len >= 8'd9) begin
                  start_acc = 1'b1;
                  state_nxt = CLEAR;
               end else begin
                  err_set = 1'b1;
               end
            end
         end
         CLEAR: begin
            if (fifo_empty) begin
               err_set   = 1'b1;
               state_nxt = IDLE;
            end else begin
               state_nxt = SEND;
            end
         end
         SEND: begin
            // Underflow aborts the frame; results already in flight still complete.
            if (fifo_empty) begin
               abort     = 1'b1;
               err_set   = 1'b1;
               state_nxt = IDLE;
            end else begin
               pop = 1'b1;
               if (idx == len_q - 8'd1) state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (drain_cnt) begin
               done_set  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 4'd1;
         if (pop)  rd_ptr <= rd_ptr + 4'd1;
         if (push && !pop)      count <= count + 5'd1;
         else if (pop && !push) count <= count - 5'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         len_q     <= '0;
         idx       <= '0;
         drain_cnt <= 1'b0;
         X         <= '0;
         cs_reset  <= 1'b1;
         err       <= 1'b0;
         done      <= 1'b0;
      end else begin
         if (start_acc) len_q <= frame_len;
         if (start_acc)  idx <= '0;
         else if (pop)   idx <= idx + 8'd1;
         drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
         if (start_acc)  X <= '0;
         else if (pop)   X <= mem[rd_ptr];
         cs_reset <= start_acc | abort;
         if (start_acc)    err <= 1'b0;
         else if (err_set) err <= 1'b1;
         done <= done_set;
      end
   end

   // vld_x travels with X, vld_y with Y one cycle later; res_valid is the registered result.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_x     <= 1'b0;
         vld_y     <= 1'b0;
         res_valid <= 1'b0;
         res_data  <= '0;
      end else begin
         vld_x     <= pop & (idx >= 8'd8);
         vld_y     <= vld_x;
         res_valid <= vld_y;
         if (vld_y) res_data <= Y;
      end
   end

`ifdef CS_FEEDER_STATS_EN
   always_ff @(posedge clk) begin
      if (reset || start_acc) begin
         res_max <= '0;
         res_cnt <= '0;
      end else if (vld_y) begin
         res_cnt <= res_cnt + 8'd1;
         if (Y > res_max) res_max <= Y;
      end
   end
`endif

endmodule
